// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT post-processing stages.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    EMIT
  } ser_state_e;

  function automatic int unsigned pow_width(input int unsigned s_width);
    return 2 * s_width;
  endfunction

endpackage

// File: rtl/frame_buffer2.sv
// Two-slot store of complete multi-channel frames; head slot is read combinationally.
module frame_buffer2 #(
  parameter int unsigned CHANELS = 2,
  parameter int unsigned S_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic                            pop,
  input  logic [CHANELS-1:0][S_WIDTH-1:0] wr_re,
  input  logic [CHANELS-1:0][S_WIDTH-1:0] wr_im,
  output logic [CHANELS-1:0][S_WIDTH-1:0] head_re,
  output logic [CHANELS-1:0][S_WIDTH-1:0] head_im,
  output logic [1:0]                      count,
  output logic                            full,
  output logic                            empty
);

  logic [1:0][CHANELS-1:0][S_WIDTH-1:0] slot_re;
  logic [1:0][CHANELS-1:0][S_WIDTH-1:0] slot_im;
  logic                                 wr_ptr;
  logic                                 rd_ptr;
  logic                                 do_wr;
  logic                                 do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A full buffer still takes a frame when the head leaves on the same edge.
  assign do_wr   = wr_en && (!full || do_pop);
  assign head_re = slot_re[rd_ptr];
  assign head_im = slot_im[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        slot_re[wr_ptr] <= wr_re;
        slot_im[wr_ptr] <= wr_im;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_wr} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fft_power_serializer.sv
// Buffers accumulator frames and streams per-channel power re^2 + im^2 one channel per beat.
module fft_power_serializer
  import fft_pkg::*;
#(
  parameter int unsigned CHANELS = 2,
  parameter int unsigned S_WIDTH = 32,
  localparam int unsigned P_WIDTH = pow_width(S_WIDTH),
  localparam int unsigned C_WIDTH = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_i,
  input  logic [CHANELS-1:0][S_WIDTH-1:0] re,
  input  logic [CHANELS-1:0][S_WIDTH-1:0] im,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [P_WIDTH-1:0]              m_power,
  output logic [C_WIDTH-1:0]              m_chan,
  output logic                            m_last,
  output logic                            overflow
);

  localparam int unsigned SQ_WIDTH = P_WIDTH - 1;
  localparam logic [C_WIDTH-1:0] LAST_CHAN = C_WIDTH'(CHANELS - 1);

  ser_state_e                      state;
  logic [C_WIDTH-1:0]              k;
  logic [SQ_WIDTH-1:0]             sq_re;
  logic [SQ_WIDTH-1:0]             sq_im;
  logic [CHANELS-1:0][S_WIDTH-1:0] head_re;
  logic [CHANELS-1:0][S_WIDTH-1:0] head_im;
  logic [1:0]                      count;
  logic                            full;
  logic                            empty;
  logic                            pop;
  logic [1:0]                      count_after_pop;
  logic signed [P_WIDTH-1:0]       re_ext;
  logic signed [P_WIDTH-1:0]       im_ext;

  frame_buffer2 #(
    .CHANELS (CHANELS),
    .S_WIDTH (S_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (valid_i),
    .pop     (pop),
    .wr_re   (re),
    .wr_im   (im),
    .head_re (head_re),
    .head_im (head_im),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign re_ext = {{S_WIDTH{head_re[k][S_WIDTH-1]}}, head_re[k]};
  assign im_ext = {{S_WIDTH{head_im[k][S_WIDTH-1]}}, head_im[k]};

  assign pop             = (state == EMIT) && m_valid && m_ready && m_last;
  assign count_after_pop = count + {1'b0, valid_i} - 2'd1;
  // Each square is at most 2^(2*S_WIDTH-2), so the sum cannot carry out of P_WIDTH.
  assign m_power         = {1'b0, sq_re} + {1'b0, sq_im};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      sq_re    <= '0;
      sq_im    <= '0;
      m_valid  <= 1'b0;
      m_chan   <= '0;
      m_last   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (valid_i && full && !pop) begin
        overflow <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!empty) begin
            k     <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          sq_re   <= SQ_WIDTH'(re_ext * re_ext);
          sq_im   <= SQ_WIDTH'(im_ext * im_ext);
          m_chan  <= k;
          m_last  <= (k == LAST_CHAN);
          m_valid <= 1'b1;
          state   <= EMIT;
        end
        EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (!m_last) begin
              k     <= k + C_WIDTH'(1);
              state <= MUL;
            end else begin
              k     <= '0;
              state <= (count_after_pop != 2'd0) ? MUL : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_power_serializer.sv
// Randomised scoreboard bench for fft_power_serializer with directed corner cases.
module tb_fft_power_serializer;

  logic              clk;
  logic              rst;
  logic              valid_i;
  logic [1:0][31:0]  re;
  logic [1:0][31:0]  im;
  logic              m_valid;
  logic              m_ready;
  logic [63:0]       m_power;
  logic [0:0]        m_chan;
  logic              m_last;
  logic              overflow;

  typedef struct packed {
    logic [63:0] power;
    logic [0:0]  chan;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t prev_beat;
  int    n_cmp   = 0;
  int    n_fail  = 0;
  int    n_beats = 0;
  int    occ     = 0;
  logic  mdl_ovf = 1'b0;
  logic  hold_prev = 1'b0;

  fft_power_serializer #(
    .CHANELS (2),
    .S_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .re       (re),
    .im       (im),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_power  (m_power),
    .m_chan   (m_chan),
    .m_last   (m_last),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pw(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sa + sb * sb;
  endfunction

  // Model: frames enter a 2-deep queue unless full with no pop on the same edge.
  always begin
    bit    pop_now;
    beat_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      exp_q.delete();
      occ       = 0;
      mdl_ovf   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      check("overflow_flag", overflow, mdl_ovf);
      if (hold_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_power", m_power, prev_beat.power);
        check("hold_chan", m_chan, prev_beat.chan);
        check("hold_last", m_last, prev_beat.last);
      end
      if (m_valid && m_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got power 0x%0h chan %0d, expected no beat",
                   m_power, m_chan);
        end else begin
          e = exp_q.pop_front();
          check("beat_power", m_power, e.power);
          check("beat_chan", m_chan, e.chan);
          check("beat_last", m_last, e.last);
        end
      end
      pop_now = m_valid && m_ready && m_last;
      if (valid_i) begin
        if (occ < 2 || pop_now) begin
          for (int c = 0; c < 2; c++) begin
            e.power = pw(re[c], im[c]);
            e.chan  = c[0:0];
            e.last  = (c == 1);
            exp_q.push_back(e);
          end
          occ++;
        end else begin
          mdl_ovf = 1'b1;
        end
      end
      if (pop_now && occ > 0) occ--;
      hold_prev = m_valid && !m_ready;
      prev_beat = '{power: m_power, chan: m_chan, last: m_last};
    end
  end

  task automatic rand_frame();
    for (int c = 0; c < 2; c++) begin
      re[c] = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom();
      im[c] = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom();
    end
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1 rst = 1'b1;
    valid_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, m_valid, 1);
  endtask

  initial begin
    int          b0;
    bit          found;
    logic [63:0] first_pw;

    rst     = 1'b1;
    valid_i = 1'b1;
    m_ready = 1'b1;
    re      = '0;
    im      = '0;

    // Reset held two cycles with a frame strobe present.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_power", m_power, 0);
    check("rst_m_chan", m_chan, 0);
    check("rst_m_last", m_last, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    valid_i = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_beat", n_beats, 0);
    check("rst_idle_valid", m_valid, 0);

    // Single frame, exact beat timing.
    @(posedge clk);
    #1;
    re[0] = 32'd3;
    re[1] = -32'sd5;
    im[0] = 32'd4;
    im[1] = 32'd12;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    check("lat_e0_valid", m_valid, 0);
    @(negedge clk);
    check("lat_e1_valid", m_valid, 0);
    @(negedge clk);
    check("lat_e2_valid", m_valid, 1);
    check("b0_power", m_power, 64'd25);
    check("b0_chan", m_chan, 0);
    check("b0_last", m_last, 0);
    @(negedge clk);
    check("b0_gap_valid", m_valid, 0);
    @(negedge clk);
    check("b1_valid", m_valid, 1);
    check("b1_power", m_power, 64'd169);
    check("b1_chan", m_chan, 1);
    check("b1_last", m_last, 1);
    @(negedge clk);
    check("b1_drop_valid", m_valid, 0);

    // Most negative input on both components.
    @(posedge clk);
    #1;
    re = '0;
    im = '0;
    re[0] = 32'h8000_0000;
    im[0] = 32'h8000_0000;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    wait_valid("ext_valid");
    check("ext_power", m_power, 64'h8000_0000_0000_0000);
    check("ext_chan", m_chan, 0);
    repeat (10) @(posedge clk);

    // Three back-to-back frames into a stalled sink: third is dropped.
    @(posedge clk);
    #1 m_ready = 1'b0;
    first_pw = '0;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      if (f == 0) first_pw = pw(re[0], im[0]);
      valid_i = 1'b1;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    repeat (6) @(negedge clk);
    check("ovf_set", overflow, 1);
    check("ovf_head_valid", m_valid, 1);
    check("ovf_head_power", m_power, first_pw);
    repeat (4) @(negedge clk);
    check("ovf_hold_power", m_power, first_pw);
    check("ovf_hold_chan", m_chan, 0);
    b0 = n_beats;
    @(posedge clk);
    #1 m_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #3;
    check("ovf_beat_count", n_beats - b0, 4);

    // Frame arriving on the pop edge of a full buffer is kept.
    reset_dut();
    m_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      rand_frame();
      valid_i = 1'b1;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    b0 = n_beats;
    m_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      #1;
      if (m_valid && m_last) found = 1'b1;
    end
    check("pop_edge_seen", found, 1);
    rand_frame();
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #3;
    check("pop_edge_beats", n_beats - b0, 6);
    check("pop_edge_no_ovf", overflow, 0);

    // Reset while a beat is being presented.
    reset_dut();
    m_ready = 1'b0;
    rand_frame();
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    wait_valid("midrst_emit");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", m_valid, 0);
    b0 = n_beats;
    m_ready = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_beats", n_beats - b0, 0);

    // Random traffic with random backpressure.
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      rand_frame();
      valid_i = ($urandom_range(2) == 0);
      m_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    m_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #3;
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
